// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared state encoding and default parameters for the PC fetch controller
package pc_ctrl_pkg;
   typedef enum logic [2:0] {
      ST_IDLE, ST_INIT, ST_FETCH, ST_WAIT, ST_ISSUE, ST_UPDATE, ST_HALTED, ST_ERROR
   } state_e;
   localparam int          PC_WIDTH_D     = 32;
   localparam logic [31:0] RESET_VECTOR_D = 32'h0000_0000;
   localparam int          PC_STEP_D      = 4;
   localparam int          MAX_WAIT_D     = 15;
endpackage

// File: rtl/pc_wait_timer.sv
// pc_wait_timer: clear/enable counter whose tc flags the last allowed un-acked wait cycle
module pc_wait_timer #(
   parameter int MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int W = $clog2(MAX + 1);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : en ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
   assign tc = cnt_q == W'(MAX - 1);
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC fetch sequencer; PC_ALIGN_CHECK_EN adds misaligned-redirect trap and misalign_err
module pc_fetch_ctrl import pc_ctrl_pkg::*; #(
   parameter int                  PC_WIDTH     = PC_WIDTH_D,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_D),
   parameter int                  PC_STEP      = PC_STEP_D,
   parameter int                  MAX_WAIT     = MAX_WAIT_D
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                halt,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ack,
   input  logic [31:0]         imem_rdata,
   output logic [31:0]         instr,
   output logic                instr_valid,
   input  logic                instr_ready,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_target,
   output logic [PC_WIDTH-1:0] pc_in,
   output logic                pc_ld,
   input  logic [PC_WIDTH-1:0] pc_out,
   output logic [31:0]         instr_count,
   output logic                busy,
   output logic                timeout_err
`ifdef PC_ALIGN_CHECK_EN
   ,output logic               misalign_err
`endif
);
   state_e              state_q, state_d;
   logic [31:0]         instr_q, instr_d, count_q, count_d;
   logic [PC_WIDTH-1:0] next_pc_q, next_pc_d;
   logic                timeout_q, timeout_d, wait_clr, wait_en, wait_tc, bad_tgt;
`ifdef PC_ALIGN_CHECK_EN
   logic                misalign_q, misalign_d;
   assign bad_tgt      = redirect_valid && redirect_target[1:0] != 2'b00;
   assign misalign_d   = misalign_q | (state_q == ST_ISSUE && instr_ready && bad_tgt);
   assign misalign_err = misalign_q;
   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end
`else
   assign bad_tgt = 1'b0;
`endif
   pc_wait_timer #(.MAX(MAX_WAIT)) u_timer (
      .clk(clk), .rst(rst), .clr(wait_clr), .en(wait_en), .tc(wait_tc)
   );
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      count_d   = count_q;
      next_pc_d = next_pc_q;
      timeout_d = timeout_q;
      wait_clr  = 1'b0;
      wait_en   = 1'b0;
      case (state_q)
         ST_IDLE:   state_d = start ? ST_INIT : ST_IDLE;
         ST_INIT:   state_d = ST_FETCH;
         ST_FETCH, ST_WAIT: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_ISSUE;
            end else if (state_q == ST_FETCH) begin
               wait_clr = 1'b1;
               state_d  = ST_WAIT;
            end else begin
               wait_en = 1'b1;
               if (wait_tc) begin
                  timeout_d = 1'b1;
                  state_d   = ST_ERROR;
               end
            end
         end
         ST_ISSUE: begin
            if (instr_ready && bad_tgt) state_d = ST_ERROR;
            else if (instr_ready) begin
               count_d   = count_q + 32'd1;
               next_pc_d = redirect_valid ? redirect_target : pc_out + PC_WIDTH'(PC_STEP);
               state_d   = ST_UPDATE;
            end
         end
         ST_UPDATE: state_d = halt ? ST_HALTED : ST_FETCH;
         ST_HALTED: state_d = (start && !halt) ? ST_FETCH : ST_HALTED;
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         count_q   <= '0;
         next_pc_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         count_q   <= count_d;
         next_pc_q <= next_pc_d;
         timeout_q <= timeout_d;
      end
   end
   assign imem_req    = state_q == ST_FETCH || state_q == ST_WAIT;
   assign imem_addr   = imem_req ? pc_out : '0;
   assign instr_valid = state_q == ST_ISSUE;
   assign instr       = instr_q;
   assign pc_ld       = state_q == ST_INIT || state_q == ST_UPDATE;
   assign pc_in       = state_q == ST_INIT ? RESET_VECTOR : next_pc_q;
   assign instr_count = count_q;
   assign busy        = !(state_q == ST_IDLE || state_q == ST_HALTED || state_q == ST_ERROR);
   assign timeout_err = timeout_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: vector table, corner-case sequences and randomized run against a transaction-level model
module tb_pc_fetch_ctrl;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, halt = 1'b0;
   logic        imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0;
   logic        redirect_valid = 1'b0, pc_ld, busy, timeout_err;
   logic [31:0] imem_addr, imem_rdata, instr, redirect_target = '0, pc_in, instr_count;
   logic [31:0] pc_reg = '0;
`ifdef PC_ALIGN_CHECK_EN
   logic        misalign_err;
`endif
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   always_ff @(posedge clk) if (pc_ld) pc_reg <= pc_in;
   assign imem_rdata = imem_ack ? imem_addr : 32'hBAD0_BAD0;
   pc_fetch_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .pc_in(pc_in), .pc_ld(pc_ld), .pc_out(pc_reg),
      .instr_count(instr_count), .busy(busy), .timeout_err(timeout_err)
`ifdef PC_ALIGN_CHECK_EN
      , .misalign_err(misalign_err)
`endif
   );
   typedef struct {
      logic        start, rv;
      logic [31:0] tgt;
      logic        req, valid, ld, bsy;
      logic [31:0] addr, ins, pcin, cnt;
   } vec_t;
   vec_t tbl [14];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int n;
      int misses;
      logic [31:0] model_pc, exp_cnt;
      tbl[0]  = '{1, 0, 0,      0, 0, 1, 1, 0,      0,      0,      0};
      tbl[1]  = '{0, 0, 0,      1, 0, 0, 1, 0,      0,      0,      0};
      tbl[2]  = '{0, 0, 0,      0, 1, 0, 1, 0,      0,      0,      0};
      tbl[3]  = '{0, 0, 0,      0, 0, 1, 1, 0,      0,      4,      1};
      tbl[4]  = '{0, 0, 0,      1, 0, 0, 1, 4,      0,      4,      1};
      tbl[5]  = '{0, 0, 0,      0, 1, 0, 1, 0,      4,      4,      1};
      tbl[6]  = '{0, 0, 0,      0, 0, 1, 1, 0,      4,      8,      2};
      tbl[7]  = '{0, 0, 0,      1, 0, 0, 1, 8,      4,      8,      2};
      tbl[8]  = '{0, 0, 0,      0, 1, 0, 1, 0,      8,      8,      2};
      tbl[9]  = '{0, 1, 'h100,  0, 0, 1, 1, 0,      8,      'h100,  3};
      tbl[10] = '{0, 0, 0,      1, 0, 0, 1, 'h100,  8,      'h100,  3};
      tbl[11] = '{0, 0, 0,      0, 1, 0, 1, 0,      'h100,  'h100,  3};
      tbl[12] = '{0, 0, 0,      0, 0, 1, 1, 0,      'h100,  'h104,  4};
      tbl[13] = '{0, 0, 0,      1, 0, 0, 1, 'h104,  'h100,  'h104,  4};
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_ld", pc_ld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc_in", pc_in, 0);
      chk("rst_timeout", timeout_err, 0);
      imem_ack = 1'b1;
      instr_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         start = tbl[i].start;
         redirect_valid = tbl[i].rv;
         redirect_target = tbl[i].tgt;
         step();
         chk($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
         chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].valid);
         chk($sformatf("tbl%0d_ld", i), pc_ld, tbl[i].ld);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("tbl%0d_instr", i), instr, tbl[i].ins);
         chk($sformatf("tbl%0d_pc_in", i), pc_in, tbl[i].pcin);
         chk($sformatf("tbl%0d_count", i), instr_count, tbl[i].cnt);
         if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      end
      start = 1'b0;
      redirect_valid = 1'b0;
      instr_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", instr_valid, 1);
         chk("stall_instr", instr, 'h104);
         chk("stall_ld", pc_ld, 0);
         chk("stall_count", instr_count, 4);
         if (i < 4) step();
      end
      instr_ready = 1'b1;
      step();
      chk("stall_release_count", instr_count, 5);
      chk("stall_release_ld", pc_ld, 1);
      chk("stall_release_pc_in", pc_in, 'h108);
      step();
      chk("halt_fetch_addr", imem_addr, 'h108);
      imem_ack = 1'b0;
      halt = 1'b1;
      step();
      step();
      chk("halt_wait_req", imem_req, 1);
      chk("halt_wait_addr", imem_addr, 'h108);
      imem_ack = 1'b1;
      step();
      chk("halt_issue_instr", instr, 'h108);
      step();
      chk("halt_update_pc_in", pc_in, 'h10C);
      step();
      chk("halted_busy", busy, 0);
      chk("halted_req", imem_req, 0);
      start = 1'b1;
      step();
      chk("halted_start_ignored", busy, 0);
      halt = 1'b0;
      step();
      start = 1'b0;
      chk("resume_req", imem_req, 1);
      chk("resume_addr", imem_addr, 'h10C);
      step();
      redirect_valid = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      step();
      chk("wrap_fetch_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      step();
      chk("wrap_pc_in", pc_in, 0);
      step();
      chk("wrap_next_addr", imem_addr, 0);
      imem_ack = 1'b0;
      n = 0;
      for (int i = 0; i < 40 && imem_req; i++) begin
         step();
         if (imem_req) n++;
      end
      chk("timeout_wait_cycles", n, 15);
      chk("timeout_err", timeout_err, 1);
      chk("timeout_req", imem_req, 0);
      chk("timeout_busy", busy, 0);
      start = 1'b1;
      imem_ack = 1'b1;
      step();
      step();
      start = 1'b0;
      chk("timeout_sticky", timeout_err, 1);
      chk("timeout_stays_error", imem_req, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("timeout_rst_clear", timeout_err, 0);
      chk("timeout_rst_count", instr_count, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      instr_ready = 1'b0;
      step();
      step();
      chk("midrst_valid_before", instr_valid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", instr_valid, 0);
      chk("midrst_req", imem_req, 0);
      chk("midrst_instr", instr, 0);
      chk("midrst_pc_in", pc_in, 0);
      chk("midrst_ld", pc_ld, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      model_pc = 32'h0;
      exp_cnt = 32'h0;
      misses = 0;
      for (int i = 0; i < 2500; i++) begin
         imem_ack = (misses >= 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
         instr_ready = $urandom_range(0, 2) != 0;
         redirect_valid = $urandom_range(0, 3) == 0;
         redirect_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         halt = $urandom_range(0, 15) == 0;
         start = $urandom_range(0, 3) == 0;
         if (imem_req) begin
            chk("rnd_addr", imem_addr, model_pc);
            misses = imem_ack ? 0 : misses + 1;
         end
         if (instr_valid && instr_ready) begin
            chk("rnd_instr", instr, model_pc);
            model_pc = redirect_valid ? redirect_target : model_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
         end
         step();
      end
      chk("rnd_count", instr_count, exp_cnt);
      chk("rnd_progress", 32'(exp_cnt > 200), 1);
      chk("rnd_no_timeout", timeout_err, 0);
      start = 1'b0;
      halt = 1'b0;
      redirect_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      imem_ack = 1'b1;
      instr_ready = 1'b0;
      step();
      step();
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_target = 32'h102;
      step();
      redirect_valid = 1'b0;
      chk("misalign_err", misalign_err, 1);
      chk("misalign_count", instr_count, 0);
      chk("misalign_ld", pc_ld, 0);
      chk("misalign_busy", busy, 0);
      step();
      chk("misalign_sticky", misalign_err, 1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
